// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: opcodes, funct3 values,
// op selector codes and immediate range limits.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        OpAddi = 2'b00,
        OpLw   = 2'b01,
        OpSw   = 2'b10,
        OpBeq  = 2'b11
    } op_e;

    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input / word-output bundle of the instruction encoder. The slave side
// is the encoder, the master side is the field producer and word consumer.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0]        op_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [31:0]       imm_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] addr_o;
    logic              err_o;
    logic [7:0]        err_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, addr_o, err_o, err_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, addr_o, err_o, err_cnt_o
    );

endinterface

// File: rtl/instr_encoder_enc_fifo.sv
// Synchronous FIFO for {address, word} pairs. Head data reads zero when empty;
// flush empties the queue and wins over push and pop.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs ADDI/LW/SW/BEQ fields into RV32I words, rejects out-of-range
// immediates and queues legal words with their byte addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    instr_encoder_if.slave  bus
);
    logic [31:0]        word;
    logic               legal, imm_i_ok, imm_b_ok;
    logic               accept, push;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               full, empty;
    logic [ADDR_W+31:0] head;

    assign imm_i_ok = ($signed(bus.imm_i) >= IMM_I_MIN) && ($signed(bus.imm_i) <= IMM_I_MAX);
    assign imm_b_ok = ($signed(bus.imm_i) >= IMM_B_MIN) && ($signed(bus.imm_i) <= IMM_B_MAX)
                      && !bus.imm_i[0];

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (op_e'(bus.op_i))
            OpAddi: begin
                word  = {bus.imm_i[11:0], bus.rs1_i, F3_ADD, bus.rd_i, OPC_ADDI};
                legal = imm_i_ok;
            end
            OpLw: begin
                word  = {bus.imm_i[11:0], bus.rs1_i, F3_W, bus.rd_i, OPC_LW};
                legal = imm_i_ok;
            end
            OpSw: begin
                word  = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, F3_W, bus.imm_i[4:0], OPC_SW};
                legal = imm_i_ok;
            end
            OpBeq: begin
                word  = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, F3_BEQ,
                         bus.imm_i[4:1], bus.imm_i[11], OPC_BEQ};
                legal = imm_b_ok;
            end
            default: ;
        endcase
    end

    assign accept = bus.in_valid_i && !full && !bus.flush_i;
    assign push   = accept && legal;

    always_comb begin
        addr_d    = addr_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (bus.flush_i) begin
            addr_d    = BASE_ADDR;
            err_cnt_d = '0;
        end else if (push) begin
            addr_d = addr_q + ADDR_W'(4);
        end else if (accept) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 32)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .flush (bus.flush_i),
        .push  (push),
        .wdata ({addr_q, word}),
        .pop   (bus.out_ready_i),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready_o  = !full;
    assign bus.out_valid_o = !empty;
    assign bus.inst_o      = head[31:0];
    assign bus.addr_o      = head[ADDR_W+31:32];
    assign bus.err_o       = err_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule
